// File: rtl/apx_pkg.sv
// Shared types and constants for the approximate column sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package apx_pkg;

  // Sequencer FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int ERRCNT_W   = 5;

  // One result column as held in the output FIFO.
  typedef struct packed {
    logic                sum;
    logic                carry;
    logic                err;
    logic                last;
    logic                ovf;
    logic [ERRCNT_W-1:0] errcnt;
  } res_t;

  // Saturating increment of the per-frame error counter.
  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v,
                                                   input logic              inc);
    if (inc && (v != {ERRCNT_W{1'b1}})) return v + 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/apx_col_seq_if.sv
// Column-in / result-out bundle of the approximate column sequencer.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the column side, out_valid/out_ready on the result side.
// Ports: master = column producer and result consumer, slave = the sequencer.
interface apx_col_seq_if;
  import apx_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [7:0]          in_col;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic                out_sum;
  logic                out_carry;
  logic                out_err;
  logic                out_last;
  logic [ERRCNT_W-1:0] out_errcnt;
  logic                out_ovf;

  modport master (
    output in_valid, in_col, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_err, out_last, out_errcnt, out_ovf
  );

  modport slave (
    input  in_valid, in_col, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_err, out_last, out_errcnt, out_ovf
  );

endinterface

// File: rtl/apx_col_seq_rt8_apxoa.sv
// 8:2 approximate column reduction tree with two column carries in/out.
// Latency: couts combinational; sum/carry/err registered one cycle after en.
// Backpressure: none; en qualifies the capture of the registered results.
// Ports: x/cin1/cin2 column inputs, cout1/cout2 carries to the next column,
//        sum_q/carry_q/err_q registered results.
module rt8_apxoa (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] x,
  input  logic       cin1,
  input  logic       cin2,
  output logic       cout1,
  output logic       cout2,
  output logic       sum_q,
  output logic       carry_q,
  output logic       err_q
);

  logic [3:0] ones;
  logic [3:0] exact;
  logic [3:0] rem;
  logic [3:0] approx;
  logic       sum_c;
  logic       carry_c;
  logic       err_c;

  // Column carries come from fixed pairs of each half; they never exceed what
  // the column holds, so rem below cannot underflow. The single carry bit can
  // only represent up to 3 of the remainder; larger remainders are truncated
  // and flagged as err.
  always_comb begin
    ones = '0;
    for (int i = 0; i < 8; i++) ones = ones + {3'b000, x[i]};
    exact   = ones + {3'b000, cin1} + {3'b000, cin2};
    cout1   = (x[0] & x[1]) | (x[2] & x[3]);
    cout2   = (x[4] & x[5]) | (x[6] & x[7]);
    rem     = exact - {2'b00, cout1, 1'b0} - {2'b00, cout2, 1'b0};
    sum_c   = ^{x, cin1, cin2};
    carry_c = (rem >= 4'd2);
    approx  = {3'b000, sum_c} + {2'b00, carry_c, 1'b0}
            + {2'b00, cout1, 1'b0} + {2'b00, cout2, 1'b0};
    err_c   = (approx != exact);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (en) begin
      sum_q   <= sum_c;
      carry_q <= carry_c;
      err_q   <= err_c;
    end
  end

endmodule

// File: rtl/apx_col_seq.sv
// Sequences frames of 8-bit columns through the approximate tree, appends one flush column per frame.
// Latency: issue in cycle N -> FIFO push end of N+1 -> out_valid in N+2; 1 column/cycle sustained.
// Backpressure: in_ready drops when the 2-entry result FIFO plus in-flight result would overflow, and in FLUSH.
// Ports: clk, rst_n (async, active-low), bus (slave side of apx_col_seq_if).
module apx_col_seq
  import apx_pkg::*;
#(
  parameter int MAX_COLS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  apx_col_seq_if.slave bus
);

  localparam int CNT_W = 5;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 2;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    col_cnt_q;
  logic                cin1_q, cin2_q;
  logic                ovf_q;
  logic                pend_q, pend_last_q, pend_ovf_q;
  logic [ERRCNT_W-1:0] errcnt_q;
  res_t                fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      fifo_cnt_q;

  logic                pop, room, accept, flush_issue, issue, frame_end;
  logic [OCC_W-1:0]    occ;
  logic [7:0]          tree_x;
  logic                cout1, cout2, t_sum, t_carry, t_err;
  logic [ERRCNT_W-1:0] errcnt_nxt;
  res_t                push_res, head;

  assign pop = bus.out_valid & bus.out_ready;
  // Space check counts the result still in the tree register (pend_q) and
  // credits a pop happening this cycle.
  assign occ  = OCC_W'(fifo_cnt_q) + OCC_W'(pend_q);
  assign room = (occ <= (OCC_W'(pop) + OCC_W'(1)));

  // Gated by rst_n so in_ready is low while reset is held.
  assign bus.in_ready = rst_n & (state_q != ST_FLUSH) & room;
  assign accept       = bus.in_valid & bus.in_ready;
  assign flush_issue  = (state_q == ST_FLUSH) & room;
  assign issue        = accept | flush_issue;
  assign frame_end    = accept & (bus.in_last | (col_cnt_q == CNT_W'(MAX_COLS - 1)));
  assign tree_x       = (state_q == ST_FLUSH) ? 8'h00 : bus.in_col;

  rt8_apxoa u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (issue),
    .x       (tree_x),
    .cin1    (cin1_q),
    .cin2    (cin2_q),
    .cout1   (cout1),
    .cout2   (cout2),
    .sum_q   (t_sum),
    .carry_q (t_carry),
    .err_q   (t_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = frame_end ? ST_FLUSH : ST_RUN;
      ST_RUN:   if (frame_end) state_d = ST_FLUSH;
      ST_FLUSH: if (flush_issue) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cin1_q      <= 1'b0;
      cin2_q      <= 1'b0;
      col_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_ovf_q  <= 1'b0;
      errcnt_q    <= '0;
    end else begin
      if (accept) begin
        cin1_q    <= cout1;
        cin2_q    <= cout2;
        col_cnt_q <= frame_end ? '0 : col_cnt_q + 1'b1;
        // Truncated only if the column limit ended the frame, not in_last.
        if (frame_end) ovf_q <= ~bus.in_last;
      end else if (flush_issue) begin
        // Next frame starts with clear carries.
        cin1_q <= 1'b0;
        cin2_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
      pend_q      <= issue;
      pend_last_q <= flush_issue;
      pend_ovf_q  <= ovf_q;
      if (pend_q) errcnt_q <= pend_last_q ? '0 : errcnt_nxt;
    end
  end

  assign errcnt_nxt = sat_inc(errcnt_q, t_err);

  always_comb begin
    push_res        = '0;
    push_res.sum    = t_sum;
    push_res.carry  = t_carry;
    push_res.err    = t_err;
    push_res.last   = pend_last_q;
    push_res.ovf    = pend_last_q & pend_ovf_q;
    push_res.errcnt = errcnt_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (pend_q) begin
        fifo_q[wr_ptr_q] <= push_res;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      fifo_cnt_q <= fifo_cnt_q + (PTR_W+1)'(pend_q) - (PTR_W+1)'(pop);
    end
  end

  // Data is masked with out_valid so an empty FIFO shows all zeros.
  assign head           = fifo_q[rd_ptr_q];
  assign bus.out_valid  = (fifo_cnt_q != '0);
  assign bus.out_sum    = bus.out_valid & head.sum;
  assign bus.out_carry  = bus.out_valid & head.carry;
  assign bus.out_err    = bus.out_valid & head.err;
  assign bus.out_last   = bus.out_valid & head.last;
  assign bus.out_ovf    = bus.out_valid & head.ovf;
  assign bus.out_errcnt = head.errcnt & {ERRCNT_W{bus.out_valid}};

endmodule

// File: tb/tb_apx_col_seq.sv
// Directed bench for apx_col_seq: frames, flush, truncation, stall, back-to-back, reset.
// Latency: n/a (bench).
// Backpressure: drives out_ready low/high to exercise FIFO stalls.
module tb_apx_col_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   acc_cyc[$];
  logic [9:0] rq[$];   // observed {sum,carry,err,last,ovf,errcnt}
  logic [9:0] exq[$];  // expected, same layout

  apx_col_seq_if bus();

  apx_col_seq #(.MAX_COLS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready)
      rq.push_back({bus.out_sum, bus.out_carry, bus.out_err, bus.out_last, bus.out_ovf, bus.out_errcnt});
    if (bus.in_valid && bus.in_ready) begin
      acc_cnt++;
      acc_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ex(input logic [2:0] sce, input logic last,
                                     input logic ovf, input logic [4:0] ec);
    return {sce, last, ovf, ec};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic l);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_col   = c;
    bus.in_last  = l;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("in_ready_wait", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Compares popped results to exq; non-last entries compare sum/carry/err/last only.
  task automatic check_results(input string tag);
    logic [9:0] e, r;
    int idx;
    idx = 0;
    for (int n = 0; n < 200 && rq.size() < exq.size(); n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_count"}, 32'(rq.size()), 32'(exq.size()));
    while (exq.size() > 0 && rq.size() > 0) begin
      e = exq.pop_front();
      r = rq.pop_front();
      if (e[6]) chk($sformatf("%s_r%0d", tag, idx), 32'(r), 32'(e));
      else      chk($sformatf("%s_r%0d", tag, idx), 32'(r[9:6]), 32'(e[9:6]));
      idx++;
    end
    rq.delete();
    exq.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_col    = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    #3;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'({bus.out_sum, bus.out_carry, bus.out_err, bus.out_last,
                             bus.out_ovf, bus.out_errcnt}), 32'd0);
    #9 rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;

    // Single 0x01 column.
    sync();
    send(8'h01, 1'b1);
    exq.push_back(ex(3'b100, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b000, 1'b1, 1'b0, 5'd0));
    check_results("f01");

    // Single 0xFF column: err, then flush carries in both cins.
    sync();
    send(8'hFF, 1'b1);
    exq.push_back(ex(3'b011, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b010, 1'b1, 1'b0, 5'd1));
    check_results("fFF");

    // 16 columns without in_last: truncated frame.
    sync();
    for (int i = 0; i < 16; i++) send(8'hFF, 1'b0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 16; i++) exq.push_back(ex(3'b011, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b010, 1'b1, 1'b1, 5'd16));
    check_results("ovf");

    // in_last on the 16th column: not an overflow.
    sync();
    for (int i = 0; i < 15; i++) send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    for (int i = 0; i < 16; i++) exq.push_back(ex(3'b000, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b000, 1'b1, 1'b0, 5'd0));
    check_results("last16");

    // Output stall for 10 cycles with a stream pending.
    sync();
    bus.out_ready = 1'b0;
    begin
      int a0;
      a0 = acc_cnt;
      fork
        begin
          send(8'h01, 1'b0);
          send(8'h03, 1'b0);
          send(8'h07, 1'b0);
          send(8'h0F, 1'b0);
          send(8'h1F, 1'b1);
        end
        begin
          repeat (10) @(negedge clk);
          #2;
          chk("stall_accepts", 32'(acc_cnt - a0), 32'd2);
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
          chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_head", 32'({bus.out_sum, bus.out_carry, bus.out_err}), 32'b100);
          chk("stall_popped", 32'(rq.size()), 32'd0);
          @(posedge clk);
          #1;
          bus.out_ready = 1'b1;
        end
      join
    end
    exq.push_back(ex(3'b100, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b000, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b010, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b110, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b011, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b100, 1'b1, 1'b0, 5'd1));
    check_results("stall");

    // Back-to-back frames at full rate; second frame starts with cin=0.
    sync();
    acc_cyc.delete();
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b1);
    send(8'h03, 1'b1);
    chk("b2b_acc_n", 32'(acc_cyc.size()), 32'd4);
    if (acc_cyc.size() == 4) begin
      chk("b2b_rate", 32'(acc_cyc[2] - acc_cyc[0]), 32'd2);
      chk("b2b_gap", 32'(acc_cyc[3] - acc_cyc[2]), 32'd2);
    end
    exq.push_back(ex(3'b011, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b011, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b011, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b010, 1'b1, 1'b0, 5'd3));
    exq.push_back(ex(3'b000, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b100, 1'b1, 1'b0, 5'd0));
    check_results("b2b");

    // Reset in RUN after 3 columns with a result held in the FIFO.
    sync();
    send(8'h07, 1'b0);
    send(8'h1F, 1'b0);
    send(8'hFF, 1'b0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("pre_rst_head", 32'({bus.out_carry, bus.out_err}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_data", 32'({bus.out_sum, bus.out_carry, bus.out_err, bus.out_last,
                             bus.out_ovf, bus.out_errcnt}), 32'd0);
    rq.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_no_result", 32'(rq.size()), 32'd0);

    // Fresh frame after reset uses cleared carries.
    sync();
    send(8'h01, 1'b1);
    exq.push_back(ex(3'b100, 1'b0, 1'b0, 5'd0));
    exq.push_back(ex(3'b000, 1'b1, 1'b0, 5'd0));
    check_results("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
